// File: rtl/i2c_slave.sv
// i2c_slave: write-only I2C target. Receives bytes addressed to SLAVE_ADDRESS
// (write direction only), ACKs the address and every data byte, and presents
// each completed data byte on data_out together with a one-clk data_ready
// pulse. Reads and foreign addresses are NACKed and ignored until the next
// START.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   scl        I2C clock from the master (input only)
//   sda        I2C data, open-drain: pulled low for ACK, otherwise high-Z
//   data_out   last fully received data byte
//   data_ready one-clk pulse when data_out is updated
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'h42
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] data_out,
   output logic       data_ready
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      DATA     = 3'd3,
      DATA_ACK = 3'd4
   } state_t;

   state_t     state, state_next;
   logic [7:0] shift_reg, shift_next;
   logic [2:0] bit_cnt, cnt_next;
   logic       sda_low, sda_low_next;
   logic [7:0] dout_next;
   logic       dr_next;

   // Two-flop synchronisers plus a third delayed copy for edge detection.
   // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
   logic scl_s1, scl_s2, scl_d;
   logic sda_s1, sda_s2, sda_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
      end else begin
         scl_s1 <= scl;
         scl_s2 <= scl_s1;
         scl_d  <= scl_s2;
         sda_s1 <= sda;
         sda_s2 <= sda_s1;
         sda_d  <= sda_s2;
      end
   end

   logic scl_rise, scl_fall, start_cond, stop_cond;
   logic [7:0] rx_byte;

   assign scl_rise   = scl_s2 & ~scl_d;
   assign scl_fall   = ~scl_s2 & scl_d;
   // SDA may only change while SCL is high for START/STOP; requiring both
   // the current and delayed SCL copies high rejects an SCL edge coinciding
   // with an SDA change.
   assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
   assign rx_byte    = {shift_reg[6:0], sda_s2};

   // Open-drain output: never drives a 1.
   assign sda = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_reg  <= 8'h00;
         bit_cnt    <= 3'd0;
         sda_low    <= 1'b0;
         data_out   <= 8'h00;
         data_ready <= 1'b0;
      end else begin
         state      <= state_next;
         shift_reg  <= shift_next;
         bit_cnt    <= cnt_next;
         sda_low    <= sda_low_next;
         data_out   <= dout_next;
         data_ready <= dr_next;
      end
   end

   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      cnt_next     = bit_cnt;
      sda_low_next = sda_low;
      dout_next    = data_out;
      dr_next      = 1'b0;

      if (stop_cond) begin
         state_next   = IDLE;
         cnt_next     = 3'd0;
         sda_low_next = 1'b0;
      end else if (start_cond) begin
         state_next   = ADDR;
         cnt_next     = 3'd0;
         sda_low_next = 1'b0;
      end else begin
         case (state)
            ADDR, DATA: begin
               if (scl_rise) begin
                  shift_next = rx_byte;
                  cnt_next   = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     cnt_next = 3'd0;
                     if (state == ADDR) begin
                        if (rx_byte[7:1] == SLAVE_ADDRESS && !rx_byte[0])
                           state_next = ADDR_ACK;
                        else
                           state_next = IDLE;
                     end else begin
                        dout_next  = rx_byte;
                        dr_next    = 1'b1;
                        state_next = DATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, DATA_ACK: begin
               // First SCL fall after the 8th bit starts the ACK; the next
               // fall (end of the 9th clock) ends it.
               if (scl_fall) begin
                  if (!sda_low) begin
                     sda_low_next = 1'b1;
                  end else begin
                     sda_low_next = 1'b0;
                     cnt_next     = 3'd0;
                     state_next   = DATA;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master, a data_ready
// monitor with an expected-byte queue, and a summary report.
module tb_i2c_slave;

   logic       clk;
   logic       rst_n;
   logic       m_scl;
   logic       m_sda;
   wire        sda;
   logic [7:0] data_out;
   logic       data_ready;

   logic [7:0] exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         dr_count = 0;
   logic       prev_dr = 1'b0;

   assign sda = m_sda ? 1'bz : 1'b0;
   pullup (sda);

   i2c_slave #(.SLAVE_ADDRESS(7'h42)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl        (m_scl),
      .sda        (sda),
      .data_out   (data_out),
      .data_ready (data_ready)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: act=%h req=%h", tag, act, exp);
      end
   endtask

   // scoreboard on data_ready: width, expected byte
   always @(negedge clk) begin
      if (data_ready) begin
         dr_count++;
         chk("dr_width", {7'd0, prev_dr}, 8'd0);
         if (exp_q.size() == 0)
            chk("dr_unexpected", 8'd1, 8'd0);
         else
            chk("dr_byte", data_out, exp_q.pop_front());
      end
      prev_dr = data_ready;
   end

   // driver tasks
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wait_clk(5);
      m_scl = 1'b1; wait_clk(5);
      m_sda = 1'b0; wait_clk(5);
      m_scl = 1'b0; wait_clk(5);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wait_clk(5);
      m_scl = 1'b1; wait_clk(5);
      m_sda = 1'b1; wait_clk(5);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         m_sda = b[i]; wait_clk(3);
         m_scl = 1'b1; wait_clk(5);
         m_scl = 1'b0; wait_clk(2);
      end
   endtask

   // Full byte plus 9th clock; checks data_ready count within 4 clk of the
   // 8th rising edge and the ACK level sampled mid-high of the 9th clock.
   task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                            input logic exp_dr, input string tag);
      int dr0;
      send_bits(b, 7);
      m_sda = b[0]; wait_clk(3);
      m_scl = 1'b1;
      dr0 = dr_count;
      wait_clk(4);
      chk({tag, "_dr"}, 8'(dr_count - dr0), {7'd0, exp_dr});
      wait_clk(1);
      m_scl = 1'b0; wait_clk(2);
      m_sda = 1'b1; wait_clk(3);
      m_scl = 1'b1; wait_clk(2);
      chk({tag, "_ack"}, {7'd0, sda === 1'b0}, {7'd0, exp_ack});
      wait_clk(3);
      m_scl = 1'b0; wait_clk(2);
   endtask

   initial begin
      rst_n = 1'b0;
      m_scl = 1'b1;
      m_sda = 1'b1;
      wait_clk(3);
      chk("rst_dout", data_out, 8'h00);
      chk("rst_dr", {7'd0, data_ready}, 8'd0);
      chk("rst_sda", {7'd0, sda === 1'b1}, 8'd1);
      rst_n = 1'b1;
      wait_clk(5);

      // write 0xA5 to our address
      i2c_start();
      send_byte(8'h84, 1'b1, 1'b0, "t1_addr");
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1, 1'b1, "t1_data");
      i2c_stop();
      chk("t1_dout", data_out, 8'hA5);

      // foreign address: NACK, data_out held
      i2c_start();
      send_byte(8'h86, 1'b0, 1'b0, "t2_addr");
      send_byte(8'h55, 1'b0, 1'b0, "t2_data");
      i2c_stop();
      chk("t2_dout", data_out, 8'hA5);

      // read request: NACK, then idle (a byte without START is ignored)
      i2c_start();
      send_byte(8'h85, 1'b0, 1'b0, "t3_addr");
      send_byte(8'h84, 1'b0, 1'b0, "t3_idle");
      i2c_stop();
      chk("t3_dout", data_out, 8'hA5);

      // multi-byte write
      i2c_start();
      send_byte(8'h84, 1'b1, 1'b0, "t4_addr");
      exp_q.push_back(8'h12);
      send_byte(8'h12, 1'b1, 1'b1, "t4_d0");
      chk("t4_dout0", data_out, 8'h12);
      exp_q.push_back(8'h34);
      send_byte(8'h34, 1'b1, 1'b1, "t4_d1");
      i2c_stop();
      chk("t4_dout1", data_out, 8'h34);

      // partial byte dropped by STOP
      i2c_start();
      send_byte(8'h84, 1'b1, 1'b0, "t5_addr");
      send_bits(8'hF0, 4);
      i2c_stop();
      chk("t5_partial", data_out, 8'h34);
      i2c_start();
      send_byte(8'h84, 1'b1, 1'b0, "t5_addr2");
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1, 1'b1, "t5_data");
      i2c_stop();
      chk("t5_dout", data_out, 8'h3C);

      // partial byte dropped by repeated START
      i2c_start();
      send_byte(8'h84, 1'b1, 1'b0, "t6_addr");
      send_bits(8'h99, 3);
      i2c_start();
      send_byte(8'h84, 1'b1, 1'b0, "t6_addr2");
      exp_q.push_back(8'hC3);
      send_byte(8'hC3, 1'b1, 1'b1, "t6_data");
      i2c_stop();
      chk("t6_dout", data_out, 8'hC3);

      // reset during address ACK
      i2c_start();
      send_bits(8'h84, 8);
      m_sda = 1'b1; wait_clk(3);
      m_scl = 1'b1; wait_clk(2);
      chk("t7_ack", {7'd0, sda === 1'b0}, 8'd1);
      rst_n = 1'b0;
      #1;
      chk("t7_sda_rel", {7'd0, sda === 1'b1}, 8'd1);
      chk("t7_dout", data_out, 8'h00);
      wait_clk(3);
      m_scl = 1'b0; wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      send_byte(8'h84, 1'b0, 1'b0, "t7_nostart");
      i2c_start();
      send_byte(8'h84, 1'b1, 1'b0, "t7_addr");
      exp_q.push_back(8'h77);
      send_byte(8'h77, 1'b1, 1'b1, "t7_data");
      i2c_stop();
      chk("t7_dout2", data_out, 8'h77);
      chk("exp_q_empty", 8'(exp_q.size()), 8'd0);

      wait_clk(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
